// File: rtl/delay_sum_beamformer.sv
// -----------------------------------------------------------------------------
// delay_sum_beamformer
//
// Delay-and-sum beamformer core. Each accepted frame carries one signed PCM
// sample per channel. Every channel owns a circular buffer of DEPTH entries.
// The frame is written at the shared write pointer P. The core then walks the
// channels one per cycle and sums buffer[k][P - delay[k]] at full precision.
// The DONE step publishes the sum as a single-cycle out_valid pulse and then
// advances P.
//
// Per-channel delays are double buffered. cfg_we updates a shadow copy, and
// the shadow is copied into the active set only when a frame is accepted. A
// config change therefore never lands in the middle of a frame's sum.
//
// Handshake: a frame transfers on a rising edge where in_valid && in_ready.
// in_ready is high only in IDLE. A frame presented while in_ready is low is
// dropped and sets the sticky overrun flag. out_valid is a one-cycle pulse
// with no back-pressure. out_data holds its value between pulses.
//
// Ports:
//   clk, reset  clock; synchronous active-high reset
//   in_valid    sample frame present
//   in_ready    core can accept a frame (IDLE)
//   in_data     NUM_CH packed samples; channel k in [k*SAMPLE_W +: SAMPLE_W]
//   cfg_we      shadow delay write strobe
//   cfg_ch      channel to configure (writes with cfg_ch >= NUM_CH ignored)
//   cfg_delay   requested delay in samples, clipped to DEPTH-1
//   out_valid   one-cycle pulse when out_data updates
//   out_data    signed sum of delayed samples
//   overrun     sticky: frame presented while busy
//   dbg_state   current FSM state (0 IDLE, 1 ACCUM, 2 DONE)
// -----------------------------------------------------------------------------
module delay_sum_beamformer #(
  parameter int NUM_CH   = 4,
  parameter int SAMPLE_W = 16,
  parameter int DEPTH    = 16,
  parameter int CH_W     = $clog2(NUM_CH),
  parameter int DLY_W    = $clog2(DEPTH) + 1,
  parameter int OUT_W    = SAMPLE_W + $clog2(NUM_CH)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [NUM_CH*SAMPLE_W-1:0] in_data,
  input  logic                       cfg_we,
  input  logic [CH_W-1:0]            cfg_ch,
  input  logic [DLY_W-1:0]           cfg_delay,
  output logic                       out_valid,
  output logic [OUT_W-1:0]           out_data,
  output logic                       overrun,
  output logic [1:0]                 dbg_state
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next_state;

  logic [SAMPLE_W-1:0] r_buf [NUM_CH][DEPTH];
  logic [AW-1:0]       r_wp;
  // Delays are stored already clipped, so AW bits are enough.
  logic [AW-1:0]       r_shadow [NUM_CH];
  logic [AW-1:0]       r_active [NUM_CH];
  logic [CH_W-1:0]     r_k;
  logic [OUT_W-1:0]    r_acc;
  logic [OUT_W-1:0]    r_out_data;
  logic                r_out_valid;
  logic                r_overrun;

  logic                w_accept;
  logic                w_last_ch;
  logic [AW-1:0]       w_rd_idx;
  logic [SAMPLE_W-1:0] w_rd_sample;
  logic [OUT_W-1:0]    w_rd_ext;
  logic [AW-1:0]       w_cfg_clip;
  logic                w_cfg_in_range;

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign overrun   = r_overrun;
  assign dbg_state = r_state;

  assign w_accept  = (r_state == S_IDLE) && in_valid;
  assign w_last_ch = (r_k == CH_W'(NUM_CH - 1));

  // The AW-bit subtraction wraps naturally. This gives the mod-DEPTH lookback
  // because DEPTH is a power of two.
  assign w_rd_idx    = r_wp - r_active[r_k];
  assign w_rd_sample = r_buf[r_k][w_rd_idx];
  assign w_rd_ext    = {{(OUT_W-SAMPLE_W){w_rd_sample[SAMPLE_W-1]}}, w_rd_sample};

  assign w_cfg_clip     = (cfg_delay > DLY_W'(DEPTH - 1)) ? AW'(DEPTH - 1)
                                                          : cfg_delay[AW-1:0];
  assign w_cfg_in_range = (32'(cfg_ch) < NUM_CH);

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  // FSM next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (in_valid)  w_next_state = S_ACCUM;
      S_ACCUM: if (w_last_ch) w_next_state = S_DONE;
      S_DONE:                 w_next_state = S_IDLE;
      default:                w_next_state = S_IDLE;
    endcase
  end

  // Datapath
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < NUM_CH; k++) begin
        for (int d = 0; d < DEPTH; d++) r_buf[k][d] <= '0;
        r_shadow[k] <= '0;
        r_active[k] <= '0;
      end
      r_wp        <= '0;
      r_k         <= '0;
      r_acc       <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_out_valid <= 1'b0;

      // Shadow write. On the same edge as an accept, the active set copies
      // the old shadow value, so the new delay applies from the next frame.
      if (cfg_we && w_cfg_in_range) r_shadow[cfg_ch] <= w_cfg_clip;

      // A dropped frame touches nothing except the sticky flag.
      if (in_valid && !in_ready) r_overrun <= 1'b1;

      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            for (int k = 0; k < NUM_CH; k++) begin
              r_buf[k][r_wp] <= in_data[k*SAMPLE_W +: SAMPLE_W];
              r_active[k]    <= r_shadow[k];
            end
            r_acc <= '0;
            r_k   <= '0;
          end
        end
        S_ACCUM: begin
          r_acc <= r_acc + w_rd_ext;
          r_k   <= r_k + CH_W'(1);
        end
        S_DONE: begin
          r_out_data  <= r_acc;
          r_out_valid <= 1'b1;
          r_wp        <= r_wp + AW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_delay_sum_beamformer.sv
// -----------------------------------------------------------------------------
// tb_delay_sum_beamformer
//
// Directed bench for delay_sum_beamformer (NUM_CH=4, SAMPLE_W=16, DEPTH=16).
// Drivers push each frame's expected sum and expected out_valid cycle into
// queues. A negedge monitor pops and compares on every out_valid pulse.
// -----------------------------------------------------------------------------
module tb_delay_sum_beamformer;

  localparam int NUM_CH   = 4;
  localparam int SAMPLE_W = 16;
  localparam int DEPTH    = 16;
  localparam int CH_W     = 2;
  localparam int DLY_W    = 5;
  localparam int OUT_W    = 18;

  logic                       clk = 1'b0;
  logic                       reset = 1'b1;
  logic                       in_valid = 1'b0;
  logic                       in_ready;
  logic [NUM_CH*SAMPLE_W-1:0] in_data = '0;
  logic                       cfg_we = 1'b0;
  logic [CH_W-1:0]            cfg_ch = '0;
  logic [DLY_W-1:0]           cfg_delay = '0;
  logic                       out_valid;
  logic [OUT_W-1:0]           out_data;
  logic                       overrun;
  logic [1:0]                 dbg_state;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [OUT_W-1:0] exp_q[$];
  int               cyc_q[$];

  delay_sum_beamformer #(
    .NUM_CH(NUM_CH), .SAMPLE_W(SAMPLE_W), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_delay(cfg_delay),
    .out_valid(out_valid), .out_data(out_data), .overrun(overrun),
    .dbg_state(dbg_state)
  );

  // Clock and cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int got, input int exp_v);
    checks++;
    if (got !== exp_v) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d (cyc %0d)", name, got, exp_v, cyc);
    end
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (!reset && out_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out_valid", 1, 0);
      end else begin
        logic [OUT_W-1:0] e;
        int               ec;
        e  = exp_q.pop_front();
        ec = cyc_q.pop_front();
        check("out_data", int'($signed(out_data)), int'($signed(e)));
        check("latency_cycle", cyc, ec);
      end
    end
  end

  // Driver tasks (called at a negedge)
  task automatic do_reset();
    reset = 1'b1;
    in_valid = 1'b0;
    cfg_we = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic cfg_write(input int ch, input int dly);
    cfg_we    = 1'b1;
    cfg_ch    = CH_W'(ch);
    cfg_delay = DLY_W'(dly);
    @(posedge clk);
    #1 cfg_we = 1'b0;
    @(negedge clk);
  endtask

  function automatic logic [NUM_CH*SAMPLE_W-1:0] pack(input int c0, input int c1,
                                                       input int c2, input int c3);
    return {16'(c3), 16'(c2), 16'(c1), 16'(c0)};
  endfunction

  task automatic send_frame(input int c0, input int c1, input int c2, input int c3,
                            input int exp_v);
    int guard;
    guard = 0;
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) begin
      check("in_ready_timeout", 0, 1);
    end else begin
      in_data  = pack(c0, c1, c2, c3);
      in_valid = 1'b1;
      exp_q.push_back(OUT_W'(exp_v));
      cyc_q.push_back(cyc + NUM_CH + 2);
      @(posedge clk);
      #1 in_valid = 1'b0;
      in_data = '0;
    end
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (exp_q.size() != 0 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check("drain_timeout", exp_q.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    // 1: reset then idle
    @(negedge clk);
    do_reset();
    repeat (10) @(negedge clk);
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_data", int'(out_data), 0);
    check("rst_overrun", int'(overrun), 0);
    check("rst_state", int'(dbg_state), 0);

    // 2: all delays 0, 100 - 20 + 7 + 1 = 88
    send_frame(100, -20, 7, 1, 88);
    drain();

    // 3: ch1 delay 3, impulse of 1000 on ch1 in frame 0
    do_reset();
    cfg_write(1, 3);
    send_frame(0, 1000, 0, 0, 0);
    send_frame(0, 0, 0, 0, 0);
    send_frame(0, 0, 0, 0, 0);
    send_frame(0, 0, 0, 0, 1000);
    send_frame(0, 0, 0, 0, 0);
    drain();

    // 4: delay 31 on ch2 clips to 15; ch2 = frame index; wraps the pointer
    do_reset();
    cfg_write(2, 31);
    for (int f = 0; f < 20; f++) begin
      send_frame(0, 0, f, 0, (f >= 15) ? f - 15 : 0);
    end
    drain();

    // 5: extremes, no overflow in 18 bits
    do_reset();
    send_frame(-32768, -32768, -32768, -32768, -131072);
    send_frame(32767, 32767, 32767, 32767, 131068);
    drain();
    check("no_overrun_yet", int'(overrun), 0);

    // 6a: in_valid held high; ch0 delay 1. Drive value i+1 on all channels in
    // cycle i. Only i = 0, 6, 12 are accepted:
    //   i=0 : ch0 lookback never written = 0, + 3*1  = 3
    //   i=6 : ch0 lookback = 1,               + 3*7  = 22
    //   i=12: ch0 lookback = 7,               + 3*13 = 46
    do_reset();
    cfg_write(0, 1);
    for (int i = 0; i < 18; i++) begin
      in_data  = pack(i + 1, i + 1, i + 1, i + 1);
      in_valid = 1'b1;
      if (i == 0)  begin exp_q.push_back(OUT_W'(3));  cyc_q.push_back(cyc + NUM_CH + 2); end
      if (i == 6)  begin exp_q.push_back(OUT_W'(22)); cyc_q.push_back(cyc + NUM_CH + 2); end
      if (i == 12) begin exp_q.push_back(OUT_W'(46)); cyc_q.push_back(cyc + NUM_CH + 2); end
      if (i == 1) check("overrun_before_busy", int'(overrun), 0);
      if (i == 2) check("overrun_after_busy", int'(overrun), 1);
      @(posedge clk);
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_data  = '0;
    drain();
    check("overrun_sticky", int'(overrun), 1);

    // 6b: reset during ACCUM aborts the frame, with no pulse
    in_data  = pack(5, 5, 5, 5);
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    check("accum_state", int'(dbg_state), 1);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    check("mid_rst_in_ready", int'(in_ready), 1);
    check("mid_rst_out_valid", int'(out_valid), 0);
    check("mid_rst_out_data", int'(out_data), 0);
    check("mid_rst_overrun", int'(overrun), 0);
    repeat (10) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time limit
  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
